// File: rtl/rsa_xcel_mont_mont_mod_exp_mul_pkg.sv
// Shared definitions for the Montgomery modular exponentiation core:
// word widths, message field offsets, Montgomery radix exponent and
// the FSM state encodings used by the top level and the multiplier.
package rsa_xcel_mont_mont_mod_exp_mul_pkg;

  localparam int WORD_W = 32;
  // Bit-serial accumulator needs two guard bits: A stays below 2n and the
  // intermediate A + b + n stays below 4n.
  localparam int ACC_W  = WORD_W + 2;
  // Montgomery radix R = 2^R_EXP.
  localparam int R_EXP  = 32;
  localparam int CNT_W  = 6;
  localparam int STEP_W = $clog2(R_EXP);

  localparam int IMSG_W        = 4 * WORD_W;
  localparam int OMSG_W        = 2 * WORD_W;
  localparam int IMSG_BASE_LSB = 96;
  localparam int IMSG_ONE_LSB  = 64;
  localparam int IMSG_EXP_LSB  = 32;
  localparam int IMSG_N_LSB    = 0;
  localparam int OMSG_RES_LSB  = 32;
  localparam int OMSG_N_LSB    = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/rsa_xcel_mont_mont_mul.sv
// Radix-2 bit-serial Montgomery multiplier: o_res = a*b*2^-32 mod n.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   i_val/i_rdy         request handshake; i_a, i_b, i_n operands
//   o_val/o_rdy         response handshake; o_res result (< n)
// A request accepted in cycle s produces o_val in cycle s+33 (32 serial
// steps, final conditional subtraction folded into the last step), and
// o_val is held until o_rdy.
module rsa_xcel_mont_mont_mul
  import rsa_xcel_mont_mont_mod_exp_mul_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_val,
  output logic              i_rdy,
  input  logic [WORD_W-1:0] i_a,
  input  logic [WORD_W-1:0] i_b,
  input  logic [WORD_W-1:0] i_n,
  output logic              o_val,
  input  logic              o_rdy,
  output logic [WORD_W-1:0] o_res
);

  mul_state_e        state_q, state_d;
  logic [WORD_W-1:0] a_q, a_d;
  logic [WORD_W-1:0] b_q, b_d;
  logic [WORD_W-1:0] n_q, n_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [WORD_W-1:0] res_q, res_d;

  // One serial step: add the selected multiple of b, make A even by adding
  // n when needed, then divide by two.
  function automatic logic [ACC_W-1:0] mont_step(input logic [ACC_W-1:0]  acc,
                                                 input logic              a_bit,
                                                 input logic [WORD_W-1:0] b,
                                                 input logic [WORD_W-1:0] n);
    logic [ACC_W-1:0] t;
    t = acc + (a_bit ? {2'b00, b} : {ACC_W{1'b0}});
    if (t[0]) t = t + {2'b00, n};
    return t >> 1;
  endfunction

  // A < 2n after the serial steps, so one subtraction brings it below n.
  function automatic logic [WORD_W-1:0] final_reduce(input logic [ACC_W-1:0]  acc,
                                                     input logic [WORD_W-1:0] n);
    logic [ACC_W-1:0] n_ext;
    logic [ACC_W-1:0] diff;
    n_ext = {2'b00, n};
    diff  = acc - n_ext;
    return (acc >= n_ext) ? diff[WORD_W-1:0] : acc[WORD_W-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    n_d     = n_q;
    acc_d   = acc_q;
    step_d  = step_q;
    res_d   = res_q;
    case (state_q)
      MUL_IDLE: begin
        if (i_val) begin
          a_d     = i_a;
          b_d     = i_b;
          n_d     = i_n;
          acc_d   = '0;
          step_d  = '0;
          state_d = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        acc_d  = mont_step(acc_q, a_q[0], b_q, n_q);
        a_d    = a_q >> 1;
        step_d = step_q + 1'b1;
        if (step_q == STEP_W'(R_EXP - 1)) begin
          res_d   = final_reduce(acc_d, n_q);
          state_d = MUL_DONE;
        end
      end
      MUL_DONE: begin
        if (o_rdy) state_d = MUL_IDLE;
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MUL_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      acc_q   <= '0;
      step_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      n_q     <= n_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      res_q   <= res_d;
    end
  end

  assign i_rdy = (state_q == MUL_IDLE);
  assign o_val = (state_q == MUL_DONE);
  assign o_res = res_q;

endmodule

// File: rtl/rsa_xcel_mont_mont_mod_exp_mul.sv
// Montgomery-domain modular exponentiation: result_m = base_m^exp in
// Montgomery form (R = 2^32), right-to-left square-and-multiply using two
// Montgomery multipliers in parallel (r*b and b*b) per exponent bit.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   istream_msg[127:0]         {base_m, one_m, exp, n}; istream_val/istream_rdy
//   ostream_msg[63:0]          {result_m, n};           ostream_val/ostream_rdy
// Build option: RSA_XCEL_MONT_EARLY_EXIT_EN
//   defined   - loop ends once the remaining exponent is zero (exp==0 goes
//               straight to DONE)
//   undefined - constant-time: always 32 iterations
module rsa_xcel_mont_mont_mod_exp_mul
  import rsa_xcel_mont_mont_mod_exp_mul_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [IMSG_W-1:0] istream_msg,
  input  logic              istream_val,
  output logic              istream_rdy,
  output logic [OMSG_W-1:0] ostream_msg,
  output logic              ostream_val,
  input  logic              ostream_rdy
);

  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(R_EXP);

  // ---------------------------------------------------------------- ctrl
  state_e state_curr_q, state_curr_d;
  logic   load_en;
  logic   iter_en;
  logic   term;
  logic   mul_i_val;
  logic   mul_o_rdy;

  // ---------------------------------------------------------------- dpath
  logic [WORD_W-1:0] r_q, r_d;
  logic [WORD_W-1:0] b_q, b_d;
  logic [WORD_W-1:0] e_q, e_d;
  logic [WORD_W-1:0] n_q, n_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [WORD_W-1:0] in_base;
  logic [WORD_W-1:0] in_one;
  logic [WORD_W-1:0] in_exp;
  logic [WORD_W-1:0] in_n;
  logic [WORD_W-1:0] e_shift;
  logic [CNT_W-1:0]  cnt_inc;

  logic              r_mulrem_i_val, r_mulrem_i_rdy, r_mulrem_o_val, r_mulrem_o_rdy;
  logic              b_mulrem_i_val, b_mulrem_i_rdy, b_mulrem_o_val, b_mulrem_o_rdy;
  logic [WORD_W-1:0] r_mulrem_res;
  logic [WORD_W-1:0] b_mulrem_res;

  assign in_base = istream_msg[IMSG_BASE_LSB +: WORD_W];
  assign in_one  = istream_msg[IMSG_ONE_LSB  +: WORD_W];
  assign in_exp  = istream_msg[IMSG_EXP_LSB  +: WORD_W];
  assign in_n    = istream_msg[IMSG_N_LSB    +: WORD_W];

  assign e_shift = e_q >> 1;
  assign cnt_inc = cnt_q + 1'b1;

`ifdef RSA_XCEL_MONT_EARLY_EXIT_EN
  // The counter term is redundant for a 32-bit exponent but keeps the bound explicit.
  assign term = (e_shift == '0) || (cnt_inc == ITER_LAST);
`else
  assign term = (cnt_inc == ITER_LAST);
`endif

  assign istream_rdy = (state_curr_q == IDLE) && !reset;
  assign ostream_val = (state_curr_q == DONE);
  assign ostream_msg[OMSG_RES_LSB +: WORD_W] = r_q;
  assign ostream_msg[OMSG_N_LSB   +: WORD_W] = n_q;

  always_comb begin
    state_curr_d = state_curr_q;
    load_en      = 1'b0;
    iter_en      = 1'b0;
    mul_i_val    = 1'b0;
    mul_o_rdy    = 1'b0;
    case (state_curr_q)
      IDLE: begin
        if (istream_val && istream_rdy) begin
          load_en      = 1'b1;
          state_curr_d = SEND;
`ifdef RSA_XCEL_MONT_EARLY_EXIT_EN
          if (in_exp == '0) state_curr_d = DONE;
`endif
        end
      end
      SEND: begin
        mul_i_val = 1'b1;
        if (r_mulrem_i_rdy && b_mulrem_i_rdy) state_curr_d = RECV;
      end
      RECV: begin
        // Both multipliers share the same latency; consume them together.
        if (r_mulrem_o_val && b_mulrem_o_val) begin
          mul_o_rdy    = 1'b1;
          iter_en      = 1'b1;
          state_curr_d = term ? DONE : SEND;
        end
      end
      DONE: begin
        if (ostream_rdy) state_curr_d = IDLE;
      end
      default: state_curr_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_curr_q <= IDLE;
    else       state_curr_q <= state_curr_d;
  end

  always_comb begin
    r_d   = r_q;
    b_d   = b_q;
    e_d   = e_q;
    n_d   = n_q;
    cnt_d = cnt_q;
    if (load_en) begin
      r_d   = in_one;
      b_d   = in_base;
      e_d   = in_exp;
      n_d   = in_n;
      cnt_d = '0;
    end else if (iter_en) begin
      if (e_q[0]) r_d = r_mulrem_res;
      b_d   = b_mulrem_res;
      e_d   = e_shift;
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q   <= '0;
      b_q   <= '0;
      e_q   <= '0;
      n_q   <= '0;
      cnt_q <= '0;
    end else begin
      r_q   <= r_d;
      b_q   <= b_d;
      e_q   <= e_d;
      n_q   <= n_d;
      cnt_q <= cnt_d;
    end
  end

  assign r_mulrem_i_val = mul_i_val;
  assign b_mulrem_i_val = mul_i_val;
  assign r_mulrem_o_rdy = mul_o_rdy;
  assign b_mulrem_o_rdy = mul_o_rdy;

  rsa_xcel_mont_mont_mul r_mulrem (
    .clk   (clk),
    .reset (reset),
    .i_val (r_mulrem_i_val),
    .i_rdy (r_mulrem_i_rdy),
    .i_a   (r_q),
    .i_b   (b_q),
    .i_n   (n_q),
    .o_val (r_mulrem_o_val),
    .o_rdy (r_mulrem_o_rdy),
    .o_res (r_mulrem_res)
  );

  rsa_xcel_mont_mont_mul b_mulrem (
    .clk   (clk),
    .reset (reset),
    .i_val (b_mulrem_i_val),
    .i_rdy (b_mulrem_i_rdy),
    .i_a   (b_q),
    .i_b   (b_q),
    .i_n   (n_q),
    .o_val (b_mulrem_o_val),
    .o_rdy (b_mulrem_o_rdy),
    .o_res (b_mulrem_res)
  );

endmodule

// File: tb/tb_rsa_xcel_mont_mont_mod_exp_mul.sv
// Self-checking bench for rsa_xcel_mont_mont_mod_exp_mul: table-driven
// vectors, randomized operations against a plain-arithmetic reference,
// plus back-pressure, mid-operation reset and back-to-back sequences.
module tb_rsa_xcel_mont_mont_mod_exp_mul;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] istream_msg;
  logic         istream_val;
  logic         istream_rdy;
  logic [63:0]  ostream_msg;
  logic         ostream_val;
  logic         ostream_rdy;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rsa_xcel_mont_mont_mod_exp_mul dut (
    .clk         (clk),
    .reset       (reset),
    .istream_msg (istream_msg),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .ostream_msg (ostream_msg),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy)
  );

  typedef struct {
    logic [127:0] msg;
    logic [63:0]  exp_out;
  } vec_t;

  vec_t vecs[$];

  // ---------------- reference model (ordinary modular arithmetic)
  function automatic longint unsigned mulmod(longint unsigned a, longint unsigned b,
                                             longint unsigned n);
    return (a * b) % n;
  endfunction

  function automatic longint unsigned powmod(longint unsigned b, longint unsigned e,
                                             longint unsigned n);
    longint unsigned r = 1;
    longint unsigned x = b % n;
    while (e != 0) begin
      if (e[0]) r = mulmod(r, x, n);
      x = mulmod(x, x, n);
      e = e >> 1;
    end
    return r;
  endfunction

  // base^e in Montgomery form equals base_m^e * R^-(e-1) mod n.
  function automatic logic [31:0] ref_res(logic [31:0] base_m, logic [31:0] one_m,
                                          logic [31:0] e, logic [31:0] n);
    longint unsigned nn   = {32'd0, n};
    longint unsigned rinv = powmod((nn + 1) / 2, 32, nn);
    if (e == 0) return one_m;
    return 32'(mulmod(powmod({32'd0, base_m}, {32'd0, e}, nn),
                      powmod(rinv, {32'd0, e} - 1, nn), nn));
  endfunction

  function automatic logic [31:0] r_mod(logic [31:0] n);
    longint unsigned r = 64'h1_0000_0000;
    return 32'(r % {32'd0, n});
  endfunction

  function automatic int exp_lat(logic [31:0] e);
`ifdef RSA_XCEL_MONT_EARLY_EXIT_EN
    int bl = 0;
    for (int i = 0; i < 32; i++) if (e[i]) bl = i + 1;
    return (e == 0) ? 1 : 34 * bl + 1;
`else
    return 34 * 32 + 1;
`endif
  endfunction

  // ---------------- checking helpers
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic drive_in(input logic [127:0] m, output int acc_cyc);
    bit ok = 0;
    acc_cyc = -1;
    istream_msg = m;
    istream_val = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (istream_rdy) begin
        ok = 1;
        acc_cyc = cyc;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no istream_rdy expected rdy within 100 cycles");
    end
    @(posedge clk);
    #1;
    istream_val = 1'b0;
  endtask

  task automatic wait_out(output logic [63:0] m, output int val_cyc, output int busy_rdy);
    bit ok = 0;
    busy_rdy = 0;
    val_cyc  = -1;
    m        = '0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (ostream_val) begin
        ok = 1;
        val_cyc = cyc;
        m = ostream_msg;
        break;
      end
      if (istream_rdy) busy_rdy++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL output_timeout: got no ostream_val expected val within 1200 cycles");
    end
  endtask

  task automatic run_op(input string name, input logic [127:0] m, input logic [63:0] expv);
    int acc_c, val_c, busy;
    logic [63:0] got;
    drive_in(m, acc_c);
    wait_out(got, val_c, busy);
    @(posedge clk);
    #1;
    chk({name, "_msg"}, got, expv);
    chk({name, "_lat"}, 64'(val_c - acc_c), 64'(exp_lat(m[63:32])));
    chk({name, "_busy_rdy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc1, acc2, v1, v2, busy;
    logic [63:0] m0, m1;
    logic [31:0] n, base, e;
    bit          stable;

    reset       = 1'b1;
    istream_val = 1'b0;
    istream_msg = '0;
    ostream_rdy = 1'b1;

    // ---------------- reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_istream_rdy", 64'(istream_rdy), 64'd0);
    chk("rst_ostream_val", 64'(ostream_val), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_istream_rdy", 64'(istream_rdy), 64'd1);
    @(posedge clk);
    #1;

    // ---------------- table-driven vectors
    vecs.push_back('{128'h00000005_00000009_00000003_0000000D, 64'h00000007_0000000D});
    vecs.push_back('{128'h00000005_00000009_00000000_0000000D, 64'h00000009_0000000D});
    vecs.push_back('{128'h00000005_00000009_0000000C_0000000D, 64'h00000009_0000000D});
    vecs.push_back('{128'h00000005_00000009_00000001_0000000D, 64'h00000005_0000000D});
    vecs.push_back('{{32'hFFFFFFFE, 32'h00000001, 32'h00000002, 32'hFFFFFFFF},
                     {ref_res(32'hFFFFFFFE, 32'h1, 32'h2, 32'hFFFFFFFF), 32'hFFFFFFFF}});
    vecs.push_back('{{32'h00000002, r_mod(32'd3), 32'h00000007, 32'h00000003},
                     {ref_res(32'h2, r_mod(32'd3), 32'h7, 32'h3), 32'h00000003}});
    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].msg, vecs[i].exp_out);

    // ---------------- randomized operations
    for (int i = 0; i < 6; i++) begin
      n = $urandom | 32'd1;
      if (n < 3) n = 32'hFFFFFFFB;
      base = $urandom % n;
      e = (i % 2 == 0) ? $urandom : $urandom_range(0, 255);
      run_op($sformatf("rand%0d", i), {base, r_mod(n), e, n},
             {ref_res(base, r_mod(n), e, n), n});
    end

    // ---------------- output back-pressure held in DONE
    ostream_rdy = 1'b0;
    drive_in(128'h00000005_00000009_00000003_0000000D, acc1);
    wait_out(m0, v1, busy);
    chk("bp_msg", m0, 64'h00000007_0000000D);
    stable = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ostream_msg !== m0 || ostream_val !== 1'b1 || istream_rdy !== 1'b0) stable = 0;
    end
    chk("bp_hold_stable", 64'(stable), 64'd1);
    ostream_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_single_xfer", 64'(ostream_val), 64'd0);
    chk("bp_back_idle", 64'(istream_rdy), 64'd1);
    @(posedge clk);
    #1;

    // ---------------- reset in the middle of an iteration
    drive_in(128'h00000005_00000009_0000FFFF_0000000D, acc1);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_istream_rdy", 64'(istream_rdy), 64'd0);
    chk("midrst_ostream_val", 64'(ostream_val), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    stable = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ostream_val !== 1'b0 || istream_rdy !== 1'b1) stable = 0;
    end
    chk("midrst_no_stale", 64'(stable), 64'd1);
    @(posedge clk);
    #1;
    run_op("post_rst", 128'h00000000_00000009_00000005_0000000D, 64'h00000000_0000000D);

    // ---------------- back-to-back with ostream_rdy high
    drive_in(128'h00000005_00000009_00000003_0000000D, acc1);
    istream_msg = 128'h00000005_00000009_0000000C_0000000D;
    istream_val = 1'b1;
    wait_out(m0, v1, busy);
    chk("b2b_busy_rdy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    drive_in(128'h00000005_00000009_0000000C_0000000D, acc2);
    wait_out(m1, v2, busy);
    @(posedge clk);
    #1;
    chk("b2b_first_msg", m0, 64'h00000007_0000000D);
    chk("b2b_second_msg", m1, 64'h00000009_0000000D);
    chk("b2b_accept_gap", 64'(acc2 - v1), 64'd1);
    chk("b2b_second_lat", 64'(v2 - acc2), 64'(exp_lat(32'hC)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsa_xcel_mont_mont_mod_exp_mul.md
# rsa_xcel_mont_mont_mod_exp_mul

Montgomery-domain modular exponentiation core. It accepts a base and the Montgomery one (R mod n, R = 2^32), both already in Montgomery form, plus a 32-bit exponent and modulus. It returns base^exp in Montgomery form together with the modulus. It sits between the input converter (normal→Montgomery) and the output converter (Montgomery→normal) in the RSA accelerator; this block only multiplies.

## Interface
- No parameters; all widths fixed at 32-bit words.
- clk  in  1  clock; one clock.
- reset  in  1  reset; synchronous, active-high.
- istream_msg  in  128  [127:96] base_m, [95:64] one_m = R mod n, [63:32] exp, [31:0] n.
- istream_val  in  1  input valid.
- istream_rdy  out  1  input ready.
- ostream_msg  out  64  [63:32] result_m = base^exp·R mod n, [31:0] n passed through.
- ostream_val  out  1  output valid.
- ostream_rdy  in  1  output ready.

## Operation
- Transfer occurs when val && rdy are high at a rising edge.
- Sub-unit mont_mul(a,b) = a·b·2^-32 mod n, computed radix-2 bit-serially.
  - 32 steps of: A += a[i]·b; if A is odd, A += n; A >>= 1.
  - One final step: if A ≥ n, then A −= n.
  - Accumulator is 34 bits; result is < n.
- Registers: r (init one_m), b (init base_m), e (init exp), n, and a 6-bit iteration counter.
- FSM states, 2-bit encoding: IDLE=0, SEND=1, RECV=2, DONE=3.
- IDLE: istream_rdy=1. On transfer, load the registers. Next state is SEND, or DONE if exp==0 (early-exit build).
- SEND: assert i_val on both multipliers for one cycle.
  - r_mulrem computes r·b.
  - b_mulrem computes b·b.
- RECV: wait until both o_val are high, then consume both results in the same cycle.
  - If e[0], r ← r_mulrem result.
  - b ← b_mulrem result.
  - e ← e>>1; counter increments.
  - Next state is DONE if the termination condition holds, else SEND.
- DONE: ostream_val=1, ostream_msg={r,n}, held stable until transfer; then go to IDLE.
- Requirements on the caller: n odd, 3 ≤ n < 2^32, base_m and one_m < n. If n is even, the result is unspecified but the handshake still completes.
- Reset: state=IDLE, ostream_val=0, istream_rdy=0 while reset is high, datapath registers cleared. Reset mid-operation aborts the computation; the multipliers return to idle and discard their results.

## Timing
- Multiplier: accepts in cycle s; o_val rises in cycle s+33 and is held until o_rdy.
- Each exponent iteration takes 34 cycles.
- With input accepted at cycle 0 and k iterations, ostream_val rises at cycle 34k+1.
- exp==0 in the early-exit build gives ostream_val at cycle 1.
- A new input is never accepted while busy; istream_rdy is low outside IDLE.
- Throughput: one operation per (34k+2) cycles when ostream_rdy is held high.
- Output back-pressure stalls DONE indefinitely with no loss of data.

## Configuration
- Macro RSA_XCEL_MONT_EARLY_EXIT_EN.
- Defined: the loop terminates when the shifted e becomes 0, so k = bit-length of exp and exp==0 skips directly to DONE.
- Undefined: constant-time mode. Always exactly 32 iterations (k=32, ostream_val at cycle 1089) regardless of exp.
- Results are identical in both builds; only latency differs.

## Structure
- Shared package holds:
  - the FSM state enum (IDLE/SEND/RECV/DONE);
  - word width 32;
  - message field offsets for the 128-bit and 64-bit messages;
  - R exponent 32.
- One sub-module: rsa_xcel_mont_mont_mul, the val/rdy bit-serial Montgomery multiplier.
  - Instantiated twice, as r_mulrem and b_mulrem.
  - Signals are named r_mulrem_i_val/_i_rdy/_o_val/_o_rdy and the b_ equivalents.
- Split into ctrl (register state_curr) and dpath.

## Test plan
- n=13 (one_m=9), base 2 (base_m=5), exp=3: input 128'h00000005_00000009_00000003_0000000D → output 64'h00000007_0000000D. Early-exit build: ostream_val at cycle 69.
- Same base and modulus, exp=0: → 64'h00000009_0000000D. Early-exit build: ostream_val at cycle 1. Constant-time build: ostream_val at cycle 1089.
- Fermat check, exp=12, base_m=5, n=13: → 64'h00000009_0000000D. Also exp=1 → 64'h00000005_0000000D.
- Back-pressure: hold ostream_rdy=0 for 50 cycles in DONE → msg stable, istream_rdy=0 throughout; release → single transfer, then IDLE.
- Reset asserted mid-RECV, then a new input (base_m=0, exp=5, n=13) → output 64'h00000000_0000000D, with no stale result.
- Back-to-back: two inputs with ostream_rdy tied high → second accepted the cycle after the first output transfer; both results correct.
